// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative unsigned MUL/DIV sequencer with pipeline stall and done pulse
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             req_ready,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL_RUN = 2'd1,
        S_DIV_RUN = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    // opa_q: multiplicand, or dividend shifting out while quotient shifts in
    logic [WIDTH-1:0]  opa_q;
    logic [WIDTH-1:0]  opb_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  result_q;
    logic              div_zero_q;

    logic              is_mul;
    logic              is_div;
    logic              accept;
    logic              last_iter;
    logic [WIDTH-1:0]  acc_add;
    logic [WIDTH:0]    rem_shift;
    logic              rem_ge;
    logic [WIDTH-1:0]  rem_sub;
    logic [WIDTH-1:0]  rem_next;
    logic [WIDTH-1:0]  quot_next;

    assign is_mul    = (alu_ctrl == 3'b100);
    assign is_div    = (alu_ctrl == 3'b101);
    assign accept    = (state_q == S_IDLE) & req_valid & (is_mul | is_div) & ~flush;
    assign last_iter = (cnt_q == LAST_CNT);

    assign acc_add   = acc_q + (opb_q[0] ? opa_q : '0);

    // remainder stays below the divisor, so the difference always fits in WIDTH bits
    assign rem_shift = {acc_q, opa_q[WIDTH-1]};
    assign rem_ge    = (rem_shift >= {1'b0, opb_q});
    assign rem_sub   = rem_shift[WIDTH-1:0] - opb_q;
    assign rem_next  = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
    assign quot_next = {opa_q[WIDTH-2:0], rem_ge};

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_MUL_RUN) | (state_q == S_DIV_RUN);
    assign done      = (state_q == S_DONE);
    assign stall     = busy | accept;
    assign result    = result_q;
    assign div_zero  = div_zero_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        opa_q <= src_a;
                        opb_q <= src_b;
                        acc_q <= '0;
                        cnt_q <= '0;
                        if (is_mul) begin
                            state_q <= S_MUL_RUN;
                        end else if (src_b == '0) begin
                            result_q   <= '1;
                            div_zero_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            state_q <= S_DIV_RUN;
                        end
                    end
                end
                S_MUL_RUN: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_add;
                        opa_q <= opa_q << 1;
                        opb_q <= opb_q >> 1;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_iter) begin
                            result_q   <= acc_add;
                            div_zero_q <= 1'b0;
                            state_q    <= S_DONE;
                        end
                    end
                end
                S_DIV_RUN: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= rem_next;
                        opa_q <= quot_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_iter) begin
                            result_q   <= quot_next;
                            div_zero_q <= 1'b0;
                            state_q    <= S_DONE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed and randomized checks of muldiv_sequencer against an arithmetic model
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          req_valid;
    logic [2:0]    alu_ctrl;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          req_ready;
    logic          busy;
    logic          stall;
    logic          done;
    logic [W-1:0]  result;
    logic          div_zero;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] last_result;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .alu_ctrl  (alu_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .req_ready (req_ready),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .result    (result),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_result(input logic [2:0] ctrl, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        if (ctrl == 3'b100) begin
            prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            return prod[W-1:0];
        end
        if (b == '0) return {W{1'b1}};
        return a / b;
    endfunction

    // One accepted request, then watch until done; checks latency, stall count and outputs.
    task automatic run_op(input string tag, input logic [2:0] ctrl, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        int cyc;
        int stalls;
        logic seen_busy;
        logic dz;
        @(negedge clk);
        req_valid = 1'b1;
        alu_ctrl  = ctrl;
        src_a     = a;
        src_b     = b;
        #1;
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        check({tag, " stall_accept"}, 32'(stall), 32'd1);
        stalls    = 1;
        seen_busy = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            if (stall) stalls++;
            if (busy) seen_busy = 1'b1;
            @(negedge clk);
            cyc++;
        end
        dz = (ctrl == 3'b101) && (b == '0);
        check({tag, " done_seen"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(cyc), dz ? 32'd1 : 32'(W + 1));
        check({tag, " stall_cycles"}, 32'(stalls), dz ? 32'd1 : 32'(W + 1));
        check({tag, " busy_seen"}, 32'(seen_busy), dz ? 32'd0 : 32'd1);
        check({tag, " result"}, result, model_result(ctrl, a, b));
        check({tag, " div_zero"}, 32'(div_zero), 32'(dz));
        check({tag, " stall_in_done"}, 32'(stall), 32'd0);
        check({tag, " ready_in_done"}, 32'(req_ready), 32'd0);
        last_result = model_result(ctrl, a, b);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " result_held"}, result, last_result);
    endtask

    initial begin
        int dones;
        int cyc;
        logic [2:0] rctrl;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset     = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        alu_ctrl  = 3'b000;
        src_a     = '0;
        src_b     = '0;
        last_result = '0;
        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset div_zero", 32'(div_zero), 32'd0);
        reset = 1'b1;

        run_op("mul7x6", 3'b100, 32'd7, 32'd6);
        run_op("div100/7", 3'b101, 32'd100, 32'd7);
        run_op("divmax/1", 3'b101, 32'hFFFF_FFFF, 32'd1);
        run_op("div5/0", 3'b101, 32'd5, 32'd0);
        run_op("mul_ovf0", 3'b100, 32'h0001_0000, 32'h0001_0000);
        run_op("mul_ovf1", 3'b100, 32'hFFFF_FFFF, 32'd2);

        for (int i = 0; i < 16; i++) begin
            rctrl = ($urandom_range(0, 1) == 0) ? 3'b100 : 3'b101;
            ra    = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            run_op("random", rctrl, ra, rb);
        end

        // Flush on the 10th DIV_RUN cycle, after a DIV leaving result=14.
        run_op("div_pre_flush", 3'b101, 32'd100, 32'd7);
        @(negedge clk);
        req_valid = 1'b1;
        alu_ctrl  = 3'b101;
        src_a     = 32'd12345;
        src_b     = 32'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("flush busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush to_idle", 32'(req_ready), 32'd1);
        check("flush busy", 32'(busy), 32'd0);
        check("flush result_kept", result, 32'd14);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("flush no_done", 32'(dones), 32'd0);

        // Flush in IDLE blocks acceptance.
        flush     = 1'b1;
        req_valid = 1'b1;
        alu_ctrl  = 3'b100;
        #1;
        check("flush_idle stall", 32'(stall), 32'd0);
        @(negedge clk);
        check("flush_idle busy", 32'(busy), 32'd0);
        flush     = 1'b0;
        req_valid = 1'b0;

        // Asynchronous reset in the middle of a MUL.
        src_a     = 32'd3;
        src_b     = 32'd5;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid ready", 32'(req_ready), 32'd1);
        check("rst_mid result", result, 32'd0);
        check("rst_mid div_zero", 32'(div_zero), 32'd0);
        check("rst_mid done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rst_mid no_done", 32'(dones), 32'd0);

        // Non-MUL/DIV control is ignored.
        req_valid = 1'b1;
        alu_ctrl  = 3'b000;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("ignore ready", 32'(req_ready), 32'd1);
            check("ignore stall", 32'(stall), 32'd0);
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("ignore no_activity", 32'(dones), 32'd0);
        req_valid = 1'b0;

        // req_valid held continuously: one done per accepted request.
        @(negedge clk);
        req_valid = 1'b1;
        alu_ctrl  = 3'b100;
        src_a     = 32'd9;
        src_b     = 32'd9;
        dones = 0;
        for (int i = 0; i < 70; i++) begin
            #1;
            if (done) begin
                dones++;
                check("held done_stall", 32'(stall), 32'd0);
                check("held done_ready", 32'(req_ready), 32'd0);
                check("held result", result, 32'd81);
            end
            @(negedge clk);
        end
        check("held done_count", 32'(dones), 32'd2);
        req_valid = 1'b0;
        cyc = 0;
        while (!req_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check("final idle", 32'(req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
